// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod. The master drives the count controls
// and the slave (the counter) returns the count, the terminal-count pulse and the overflow flag.
interface updown_counter_mod_if #(
  parameter int WIDTH = 16
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             ClrOvf;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             Ovf;

  modport master (
    output En, Up, Load, D, ClrOvf,
    input  Q, TC, Ovf
  );

  modport slave (
    input  En, Up, Load, D, ClrOvf,
    output Q, TC, Ovf
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, clamped parallel load, TC pulse and sticky Ovf.
// Optional build macro COUNTER_SATURATE_EN: hold at the end values instead of wrapping.
module updown_counter_mod #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input logic                 Clk,
  input logic                 Clr_n,
  updown_counter_mod_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic [WIDTH-1:0] d_clamped;
  logic             at_max;
  logic             at_zero;

  // Load values beyond the modulus are clamped so Q never leaves 0..MAX_COUNT.
  always_comb begin
    d_clamped = (bus.D > MAX_COUNT) ? MAX_COUNT : bus.D;
    at_max    = (q == MAX_COUNT);
    at_zero   = (q == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= 1'b0;
      // Clear first so an overrun on the same edge wins.
      if (bus.ClrOvf) ovf <= 1'b0;
      if (bus.Load) begin
        q <= d_clamped;
      end else if (bus.En) begin
        if (bus.Up) begin
          if (at_max) begin
            ovf <= 1'b1;
`ifdef COUNTER_SATURATE_EN
            q   <= MAX_COUNT;
`else
            q   <= '0;
            tc  <= 1'b1;
`endif
          end else begin
            q <= q + 1'b1;
          end
        end else begin
          if (at_zero) begin
            ovf <= 1'b1;
`ifdef COUNTER_SATURATE_EN
            q   <= '0;
`else
            q   <= MAX_COUNT;
            tc  <= 1'b1;
`endif
          end else begin
            q <= q - 1'b1;
          end
        end
      end
    end
  end

  assign bus.Q   = q;
  assign bus.TC  = tc;
  assign bus.Ovf = ovf;

endmodule
